// File: rtl/fir_tap_line.sv
// fir_tap_line
// Multi-channel tapped delay line feeding the FIR MAC stage. Each channel
// keeps its own sample history and fill count. Every accepted sample yields a
// one-cycle registered snapshot of that channel's full tap vector.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (clears storage and outputs)
//   flush      : synchronous clear of all taps and fill counters
//   in_valid   : in_ch / in_data valid this cycle
//   in_ch      : channel index of the input sample
//   in_data    : signed input sample
//   out_valid  : one-cycle strobe, out_* hold a new snapshot
//   out_ch     : channel of the snapshot
//   out_taps   : flattened taps, tap k at [k*WIDTH_data +: WIDTH_data], tap 0 newest
//   out_primed : channel has seen NUM_TAPS samples since reset/flush
//   err_ch     : one-cycle pulse, in_valid arrived with in_ch >= NUM_CH
module fir_tap_line #(
  parameter int WIDTH_data = 24,
  parameter int NUM_TAPS   = 8,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [CH_W-1:0]                in_ch,
  input  logic signed [WIDTH_data-1:0]   in_data,
  output logic                           out_valid,
  output logic [CH_W-1:0]                out_ch,
  output logic [NUM_TAPS*WIDTH_data-1:0] out_taps,
  output logic                           out_primed,
  output logic                           err_ch
);

  localparam int FILL_W = $clog2(NUM_TAPS + 1);
  localparam int TAPS_W = NUM_TAPS * WIDTH_data;
  // The oldest tap is only ever observed through the snapshot, so per-channel
  // storage holds taps 0..NUM_TAPS-2; the snapshot register carries the last one.
  localparam int HIST_N = NUM_TAPS - 1;

  // Fill counter increment, saturating at NUM_TAPS.
  function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] f);
    if ({1'b0, f} >= (FILL_W+1)'(NUM_TAPS))
      return f;
    return f + FILL_W'(1);
  endfunction

  // Primed once this sample brings the channel to NUM_TAPS samples.
  function automatic logic is_primed(input logic [FILL_W-1:0] f);
    return ({1'b0, f} + (FILL_W+1)'(1)) >= (FILL_W+1)'(NUM_TAPS);
  endfunction

  logic signed [WIDTH_data-1:0] hist [NUM_CH][HIST_N];
  logic [FILL_W-1:0]            fill [NUM_CH];

  logic                         ch_ok;
  logic                         accept;
  logic [FILL_W-1:0]            sel_fill;
  logic signed [WIDTH_data-1:0] shifted [NUM_TAPS];
  logic [TAPS_W-1:0]            shifted_flat;

  assign ch_ok  = {1'b0, in_ch} < (CH_W+1)'(NUM_CH);
  assign accept = in_valid & ~flush & ch_ok;

  // Stage p0: select the addressed channel and form its post-shift tap vector.
  // The select loop compares against every legal index, so an out-of-range
  // in_ch never addresses the storage arrays.
  always_comb begin
    sel_fill   = '0;
    shifted[0] = in_data;
    for (int k = 1; k < NUM_TAPS; k++) shifted[k] = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == CH_W'(c)) begin
        sel_fill = fill[c];
        for (int k = 1; k < NUM_TAPS; k++) shifted[k] = hist[c][k-1];
      end
    end
    shifted_flat = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      shifted_flat[k*WIDTH_data +: WIDTH_data] = shifted[k];
  end

  // Stage p1: storage update and registered snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fill[c] <= '0;
        for (int k = 0; k < HIST_N; k++) hist[c][k] <= '0;
      end
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_taps   <= '0;
      out_primed <= 1'b0;
      err_ch     <= 1'b0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fill[c] <= '0;
        for (int k = 0; k < HIST_N; k++) hist[c][k] <= '0;
      end
      out_valid  <= 1'b0;
      out_taps   <= '0;
      out_primed <= 1'b0;
      err_ch     <= 1'b0;
    end else begin
      out_valid <= accept;
      err_ch    <= in_valid & ~ch_ok;
      if (accept) begin
        out_taps   <= shifted_flat;
        out_ch     <= in_ch;
        out_primed <= is_primed(sel_fill);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept && in_ch == CH_W'(c)) begin
          fill[c] <= sat_inc(fill[c]);
          for (int k = 0; k < HIST_N; k++) hist[c][k] <= shifted[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_line.sv
module tb_fir_tap_line;

  localparam int W    = 24;
  localparam int NT   = 8;
  localparam int NC   = 3;
  localparam int CW   = 2;
  localparam int TW   = NT * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ch = '0;
  logic signed [W-1:0] in_data = '0;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [TW-1:0] out_taps;
  logic          out_primed;
  logic          err_ch;

  int total = 0;
  int bad   = 0;

  fir_tap_line #(
    .WIDTH_data(W),
    .NUM_TAPS  (NT),
    .NUM_CH    (NC),
    .CH_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_taps  (out_taps),
    .out_primed(out_primed),
    .err_ch    (err_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
    logic [TW-1:0] r;
    r[0*W +: W] = W'(a0);
    r[1*W +: W] = W'(a1);
    r[2*W +: W] = W'(a2);
    r[3*W +: W] = W'(a3);
    r[4*W +: W] = W'(a4);
    r[5*W +: W] = W'(a5);
    r[6*W +: W] = W'(a6);
    r[7*W +: W] = W'(a7);
    return r;
  endfunction

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [CW-1:0] ch, input int d);
    in_valid = v;
    in_ch    = ch;
    in_data  = W'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_snap(input string tag, input logic [CW-1:0] ch,
                          input logic [TW-1:0] taps, input logic primed);
    chk({tag, ".valid"},  256'(out_valid),  256'(1'b1));
    chk({tag, ".ch"},     256'(out_ch),     256'(ch));
    chk({tag, ".taps"},   256'(out_taps),   256'(taps));
    chk({tag, ".primed"}, 256'(out_primed), 256'(primed));
  endtask

  int hq[$];
  logic [TW-1:0] exp_t;

  initial begin
    // Reset with a live full-scale input: everything must stay 0.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'd0, 'h7FFFFF);
      chk("rst.valid",  256'(out_valid),  256'(0));
      chk("rst.ch",     256'(out_ch),     256'(0));
      chk("rst.taps",   256'(out_taps),   256'(0));
      chk("rst.primed", 256'(out_primed), 256'(0));
      chk("rst.err",    256'(err_ch),     256'(0));
    end
    rst = 1'b0;
    step(1'b0, 2'd0, 0);
    chk("post_rst.valid", 256'(out_valid), 256'(0));
    chk("post_rst.taps",  256'(out_taps),  256'(0));
    step(1'b1, 2'd0, 5);
    chk_snap("first", 2'd0, mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Single-channel priming on the untouched ch2: 1..10 back to back.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 2'd2, i);
      chk("prime.valid", 256'(out_valid), 256'(1));
      if (i == 7) chk("prime7.primed", 256'(out_primed), 256'(0));
    end
    chk_snap("prime10", 2'd2, mk(10, 9, 8, 7, 6, 5, 4, 3), 1'b1);

    // Channel isolation with an idle gap; sign must be preserved.
    step(1'b1, 2'd0, -1);
    chk_snap("iso0a", 2'd0, mk(-1, 5, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("iso0a.tap0", 256'(out_taps[W-1:0]), 256'(24'hFFFFFF));
    step(1'b1, 2'd1, 100);
    chk_snap("iso1a", 2'd1, mk(100, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, 2'd0, -2);
    chk_snap("iso0b", 2'd0, mk(-2, -1, 5, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, 2'd1, 200);
    chk_snap("iso1b", 2'd1, mk(200, 100, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 2'd0, 77);
      chk("idle.valid", 256'(out_valid), 256'(0));
      chk("idle.taps",  256'(out_taps),  256'(mk(200, 100, 0, 0, 0, 0, 0, 0)));
      chk("idle.ch",    256'(out_ch),    256'(1));
    end
    step(1'b1, 2'd0, -3);
    chk_snap("iso0c", 2'd0, mk(-3, -2, -1, 5, 0, 0, 0, 0), 1'b0);
    step(1'b1, 2'd1, 300);
    chk_snap("iso1c", 2'd1, mk(300, 200, 100, 0, 0, 0, 0, 0), 1'b0);

    // Bad channel: dropped, err pulses once, outputs hold.
    step(1'b1, 2'd3, 1234);
    chk("badch.err",   256'(err_ch),    256'(1));
    chk("badch.valid", 256'(out_valid), 256'(0));
    chk("badch.taps",  256'(out_taps),  256'(mk(300, 200, 100, 0, 0, 0, 0, 0)));
    step(1'b0, 2'd0, 0);
    chk("badch.err_off", 256'(err_ch), 256'(0));
    step(1'b1, 2'd1, 400);
    chk_snap("after_bad", 2'd1, mk(400, 300, 200, 100, 0, 0, 0, 0), 1'b0);
    chk("after_bad.err", 256'(err_ch), 256'(0));

    // Saturation: 3*NUM_TAPS samples on ch1; window is the last 8 inputs reversed.
    hq = '{100, 200, 300, 400};
    for (int i = 0; i < 3 * NT; i++) begin
      hq.push_back(1000 + i);
      step(1'b1, 2'd1, 1000 + i);
      exp_t = '0;
      for (int k = 0; k < NT; k++)
        if (hq.size() - 1 - k >= 0) exp_t[k*W +: W] = W'(hq[hq.size() - 1 - k]);
      chk("sat.taps",   256'(out_taps),   256'(exp_t));
      chk("sat.primed", 256'(out_primed), 256'(hq.size() >= NT));
      chk("sat.valid",  256'(out_valid),  256'(1));
    end

    // Flush overrides in_valid and suppresses err_ch.
    flush = 1'b1;
    step(1'b1, 2'd2, 9);
    chk("flush.valid",  256'(out_valid),  256'(0));
    chk("flush.primed", 256'(out_primed), 256'(0));
    chk("flush.taps",   256'(out_taps),   256'(0));
    chk("flush.ch",     256'(out_ch),     256'(1));
    step(1'b1, 2'd3, 9);
    chk("flush.err", 256'(err_ch), 256'(0));
    flush = 1'b0;
    step(1'b1, 2'd2, 3);
    chk_snap("post_flush2", 2'd2, mk(3, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(1'b1, 2'd1, 7);
    chk_snap("post_flush1", 2'd1, mk(7, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Bad channel must not disturb the fill count: ch0 at 7, then bad, then 8th.
    for (int i = 1; i <= 7; i++) step(1'b1, 2'd0, i);
    chk_snap("fill7", 2'd0, mk(7, 6, 5, 4, 3, 2, 1, 0), 1'b0);
    step(1'b1, 2'd3, 50);
    chk("fill.err", 256'(err_ch), 256'(1));
    step(1'b1, 2'd0, 8);
    chk_snap("fill8", 2'd0, mk(8, 7, 6, 5, 4, 3, 2, 1), 1'b1);
    chk("fill8.err", 256'(err_ch), 256'(0));

    // Reset mid-stream: sample in the reset cycle is lost, fill restarts.
    rst = 1'b1;
    step(1'b1, 2'd0, 99);
    chk("rst2.valid",  256'(out_valid),  256'(0));
    chk("rst2.taps",   256'(out_taps),   256'(0));
    chk("rst2.primed", 256'(out_primed), 256'(0));
    rst = 1'b0;
    step(1'b1, 2'd0, 11);
    chk_snap("rst2.first", 2'd0, mk(11, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(1'b0, 2'd0, 0);
    chk("end.valid", 256'(out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
